pcie_axi_mem_slave: RTL and testbench
=====================================

# pcie_axi_mem_slave
AXI4 slave memory model attached to the PCIe top wrapper's m_axi_* master port, serving inbound PCIe memory writes and reads. Stores 256-bit beats in a flop array and runs independent write (AW/W/B) and read (AR/R) state machines, so one write burst and one read burst can be in flight at the same time. Used as the endpoint memory in system simulation and FPGA bring-up.
## Interface
- MEM_DEPTH_LG2, 10, log2 of the number of 32-byte words (default 1024 words = 32 KB)
- BASE_ADDR, 64'h0, byte address of word 0
- clk  in  1  sole clock; all logic is on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_awid  in  6  write ID
- s_axi_awaddr  in  64  write byte address; bits [4:0] ignored
- s_axi_awlen  in  8  beats minus 1
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_wdata  in  256  write data
- s_axi_wstrb  in  32  byte enables
- s_axi_wlast  in  1  last write beat
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_bid  out  6  response ID (the latched awid)
- s_axi_bresp  out  2  write response code
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_arid  in  6  read ID
- s_axi_araddr  in  64  read byte address; bits [4:0] ignored
- s_axi_arlen  in  8  beats minus 1
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- s_axi_rid  out  6  read ID (the latched arid)
- s_axi_rdata  out  256  read data; 0 whenever rvalid=0
- s_axi_rresp  out  2  read response code
- s_axi_rlast  out  1  last read beat
- Burst type is always INCR and beat size is always 32 B. Size, burst, cache, prot, qos and region are not ported.
## Operation
- Word index = (addr - BASE_ADDR) >> 5, truncated to MEM_DEPTH_LG2 bits. The index increments once per beat and wraps modulo the memory depth.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On the AW handshake, latch id, index and len; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes selected by wstrb, counts the beat and increments the index.
  - The W handshake with wlast=1 moves the FSM to W_RESP.
  - W_RESP: bvalid=1. On bready, return to W_IDLE.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On the AR handshake, latch id, index and len; go to R_DATA.
  - R_DATA: rvalid=1 and rdata = mem[index] (combinational read). rlast=1 when beat count == len.
  - Each R handshake advances the beat. The handshake with rlast=1 returns the FSM to R_IDLE.
- A read and a write to the same word in the same cycle: the read returns the old data and the write lands at the clock edge.
- Memory contents are not reset. A reset in the middle of a burst aborts it; beats already written are kept.
- Reset values of all outputs:
  - awready=1, arready=1
  - wready=0, bvalid=0, rvalid=0, rlast=0
  - bid=0, rid=0, bresp=0, rresp=0, rdata=0
## Timing
- AW or AR accepted in cycle N: wready or rvalid is asserted in cycle N+1. There are no bubbles inside a burst.
- Last W beat accepted in cycle N: bvalid is asserted in cycle N+1 and held until bready.
- After the final B or R handshake, awready or arready returns in the next cycle. Minimum turnaround is 1 idle cycle between bursts.
- awready is 0 outside W_IDLE and arready is 0 outside R_IDLE; each direction has at most one outstanding burst.
- rdata, rid and rresp are held stable while rvalid=1 and rready=0.
## Configuration
- PCIE_AXI_MEM_ERR_CHECK_EN defined:
  - A burst whose byte range falls outside [BASE_ADDR, BASE_ADDR + 32·2^MEM_DEPTH_LG2) gets DECERR (2'b11) on every R beat, or on B. Its writes are suppressed and its reads return 0.
  - A write where wlast does not coincide with beat count == awlen gets SLVERR (2'b10). The burst still completes on wlast.
- Not defined: no checks are made, resp is always OKAY and addresses wrap silently.
## Test plan
- Reset with awvalid=arvalid=0 -> awready=arready=1; bvalid=rvalid=0; all ID, resp and data outputs 0.
- AW addr 0x40, len 3, id 5; 4 W beats with full strobes, data D0..D3; then AR addr 0x40, len 3 -> bvalid one cycle after the last W beat with bid=5, bresp=0; R returns D0..D3 with rlast only on the 4th beat.
- Write to word 2 with wstrb=32'h0000_000F over a word holding all 1s -> read returns bytes 0-3 new and bytes 4-31 still 0xFF.
- Read burst of len 7 with rready toggling 1,0,1,0 -> 8 beats, no duplicate or skipped beat, and rdata stable whenever rready=0.
- Concurrent write and read bursts to the same word in the same cycle -> the read beat returns the old value; a read issued afterwards returns the new value.
- With PCIE_AXI_MEM_ERR_CHECK_EN: write at BASE_ADDR + 0x8000 with the default depth -> bresp=2'b11 and memory unchanged. Write with awlen=3 but wlast on beat 2 -> bresp=2'b10.

Source files
------------

// File: rtl/pcie_axi_mem_slave_if.sv
// AXI4 slave-side bundle for pcie_axi_mem_slave (AW/W/B and AR/R, INCR, 32-byte beats).
// Latency: wires only.
// Backpressure: the slave modport drives the ready signals; the master modport drives the valid signals.
// Ports: write address (awvalid/awready/awid/awaddr/awlen), write data (wvalid/wready/wdata/wstrb/wlast),
//        write response (bvalid/bready/bid/bresp), read address (arvalid/arready/arid/araddr/arlen),
//        read data (rvalid/rready/rid/rdata/rresp/rlast).
interface pcie_axi_mem_slave_if;
   logic         s_axi_awvalid;
   logic         s_axi_awready;
   logic [5:0]   s_axi_awid;
   logic [63:0]  s_axi_awaddr;
   logic [7:0]   s_axi_awlen;
   logic         s_axi_wvalid;
   logic         s_axi_wready;
   logic [255:0] s_axi_wdata;
   logic [31:0]  s_axi_wstrb;
   logic         s_axi_wlast;
   logic         s_axi_bvalid;
   logic         s_axi_bready;
   logic [5:0]   s_axi_bid;
   logic [1:0]   s_axi_bresp;
   logic         s_axi_arvalid;
   logic         s_axi_arready;
   logic [5:0]   s_axi_arid;
   logic [63:0]  s_axi_araddr;
   logic [7:0]   s_axi_arlen;
   logic         s_axi_rvalid;
   logic         s_axi_rready;
   logic [5:0]   s_axi_rid;
   logic [255:0] s_axi_rdata;
   logic [1:0]   s_axi_rresp;
   logic         s_axi_rlast;

   modport slave (
      input  s_axi_awvalid, s_axi_awid, s_axi_awaddr, s_axi_awlen,
      output s_axi_awready,
      input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
      output s_axi_wready,
      output s_axi_bvalid, s_axi_bid, s_axi_bresp,
      input  s_axi_bready,
      input  s_axi_arvalid, s_axi_arid, s_axi_araddr, s_axi_arlen,
      output s_axi_arready,
      output s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
      input  s_axi_rready
   );

   modport master (
      output s_axi_awvalid, s_axi_awid, s_axi_awaddr, s_axi_awlen,
      input  s_axi_awready,
      output s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
      input  s_axi_wready,
      input  s_axi_bvalid, s_axi_bid, s_axi_bresp,
      output s_axi_bready,
      output s_axi_arvalid, s_axi_arid, s_axi_araddr, s_axi_arlen,
      input  s_axi_arready,
      input  s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
      output s_axi_rready
   );
endinterface

// File: rtl/pcie_axi_mem_slave.sv
// AXI4 slave memory of 2^MEM_DEPTH_LG2 x 256-bit flops; one write and one read burst in flight at once.
// Latency: data phase starts the cycle after AW/AR, B the cycle after the last W, 1 idle cycle between bursts.
// Backpressure: awready/arready only in idle; W/R beats stall on wvalid/rready, R outputs held while stalled.
// Ports: clk, rst_n (async, active-low), s_axi (pcie_axi_mem_slave_if.slave).
// Optional: define PCIE_AXI_MEM_ERR_CHECK_EN for DECERR on out-of-range bursts and SLVERR on a misplaced wlast.
module pcie_axi_mem_slave #(
   parameter int          MEM_DEPTH_LG2 = 10,
   parameter logic [63:0] BASE_ADDR     = 64'h0
) (
   input logic                  clk,
   input logic                  rst_n,
   pcie_axi_mem_slave_if.slave  s_axi
);
   localparam int DEPTH = 1 << MEM_DEPTH_LG2;
   typedef logic [MEM_DEPTH_LG2-1:0] idx_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_DATA} r_state_e;

   logic [255:0] mem_q [DEPTH];

   w_state_e   w_state_q, w_state_d;
   logic [5:0] w_id_q, w_id_d;
   idx_t       w_idx_q, w_idx_d;
   logic [7:0] w_len_q, w_len_d, w_cnt_q, w_cnt_d;
   logic       w_dec_q, w_dec_d, w_slv_q, w_slv_d;
   logic       mem_we;

   r_state_e   r_state_q, r_state_d;
   logic [5:0] r_id_q, r_id_d;
   idx_t       r_idx_q, r_idx_d;
   logic [7:0] r_len_q, r_len_d, r_cnt_q, r_cnt_d;
   logic       r_dec_q, r_dec_d;

   // Bit 64 is the borrow: set when the address lies below BASE_ADDR.
   logic [64:0] aw_off, ar_off;
   idx_t        aw_idx, ar_idx;
   logic        aw_oor, ar_oor, w_proto_err, unused_bits;

   assign aw_off = {1'b0, s_axi.s_axi_awaddr} - {1'b0, BASE_ADDR};
   assign ar_off = {1'b0, s_axi.s_axi_araddr} - {1'b0, BASE_ADDR};
   assign aw_idx = aw_off[MEM_DEPTH_LG2+4:5];
   assign ar_idx = ar_off[MEM_DEPTH_LG2+4:5];

`ifdef PCIE_AXI_MEM_ERR_CHECK_EN
   // Out of range if the first word is below the base or the last word of the burst is past the end.
   assign aw_oor = aw_off[64] | (({1'b0, aw_off[63:5]} + {52'd0, s_axi.s_axi_awlen}) >= 60'(DEPTH));
   assign ar_oor = ar_off[64] | (({1'b0, ar_off[63:5]} + {52'd0, s_axi.s_axi_arlen}) >= 60'(DEPTH));
   // wlast must arrive exactly on the beat numbered awlen.
   assign w_proto_err = s_axi.s_axi_wlast != (w_cnt_q == w_len_q);
   assign unused_bits = ^{aw_off[4:0], ar_off[4:0]};
`else
   assign aw_oor      = 1'b0;
   assign ar_oor      = 1'b0;
   assign w_proto_err = 1'b0;
   assign unused_bits = ^{aw_off[64:MEM_DEPTH_LG2+5], aw_off[4:0],
                          ar_off[64:MEM_DEPTH_LG2+5], ar_off[4:0], w_len_q, w_cnt_q};
`endif

   // ---------------- write channel ----------------
   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_idx_d   = w_idx_q;
      w_len_d   = w_len_q;
      w_cnt_d   = w_cnt_q;
      w_dec_d   = w_dec_q;
      w_slv_d   = w_slv_q;
      mem_we    = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (s_axi.s_axi_awvalid) begin
               w_id_d    = s_axi.s_axi_awid;
               w_idx_d   = aw_idx;
               w_len_d   = s_axi.s_axi_awlen;
               w_cnt_d   = 8'd0;
               w_dec_d   = aw_oor;
               w_slv_d   = 1'b0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (s_axi.s_axi_wvalid) begin
               mem_we  = ~w_dec_q;
               w_idx_d = w_idx_q + 1'b1;
               w_cnt_d = w_cnt_q + 8'd1;
               if (w_proto_err) w_slv_d = 1'b1;
               if (s_axi.s_axi_wlast) w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (s_axi.s_axi_bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q <= W_IDLE;
         w_id_q    <= '0;
         w_idx_q   <= '0;
         w_len_q   <= '0;
         w_cnt_q   <= '0;
         w_dec_q   <= 1'b0;
         w_slv_q   <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
         w_idx_q   <= w_idx_d;
         w_len_q   <= w_len_d;
         w_cnt_q   <= w_cnt_d;
         w_dec_q   <= w_dec_d;
         w_slv_q   <= w_slv_d;
      end
   end

   // Storage is deliberately not reset; a reset mid-burst keeps the beats already written.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 32; b++) begin
            if (s_axi.s_axi_wstrb[b]) mem_q[w_idx_q][8*b +: 8] <= s_axi.s_axi_wdata[8*b +: 8];
         end
      end
   end

   assign s_axi.s_axi_awready = (w_state_q == W_IDLE);
   assign s_axi.s_axi_wready  = (w_state_q == W_DATA);
   assign s_axi.s_axi_bvalid  = (w_state_q == W_RESP);
   assign s_axi.s_axi_bid     = w_id_q;
   // DECERR takes priority over SLVERR.
   assign s_axi.s_axi_bresp   = (w_state_q != W_RESP) ? 2'b00 :
                                w_dec_q ? 2'b11 : w_slv_q ? 2'b10 : 2'b00;

   // ---------------- read channel ----------------
   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_idx_d   = r_idx_q;
      r_len_d   = r_len_q;
      r_cnt_d   = r_cnt_q;
      r_dec_d   = r_dec_q;
      case (r_state_q)
         R_IDLE: begin
            if (s_axi.s_axi_arvalid) begin
               r_id_d    = s_axi.s_axi_arid;
               r_idx_d   = ar_idx;
               r_len_d   = s_axi.s_axi_arlen;
               r_cnt_d   = 8'd0;
               r_dec_d   = ar_oor;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (s_axi.s_axi_rready) begin
               if (r_cnt_q == r_len_q) begin
                  r_state_d = R_IDLE;
               end else begin
                  r_idx_d = r_idx_q + 1'b1;
                  r_cnt_d = r_cnt_q + 8'd1;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q <= R_IDLE;
         r_id_q    <= '0;
         r_idx_q   <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
         r_dec_q   <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_idx_q   <= r_idx_d;
         r_len_q   <= r_len_d;
         r_cnt_q   <= r_cnt_d;
         r_dec_q   <= r_dec_d;
      end
   end

   // Combinational read of the pre-edge contents: a same-cycle write to this word shows up next cycle.
   assign s_axi.s_axi_arready = (r_state_q == R_IDLE);
   assign s_axi.s_axi_rvalid  = (r_state_q == R_DATA);
   assign s_axi.s_axi_rid     = r_id_q;
   assign s_axi.s_axi_rlast   = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);
   assign s_axi.s_axi_rdata   = ((r_state_q == R_DATA) && !r_dec_q) ? mem_q[r_idx_q] : '0;
   assign s_axi.s_axi_rresp   = ((r_state_q == R_DATA) && r_dec_q) ? 2'b11 : 2'b00;
endmodule

// File: tb/tb_pcie_axi_mem_slave.sv
// Directed bench for pcie_axi_mem_slave: reset state, bursts, strobes, stalls, same-cycle read/write.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled there too.
// Expected values are hand-built patterns held in wd[] / rexp[].
module tb_pcie_axi_mem_slave;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   logic [255:0] wd   [16];
   logic [255:0] rexp [16];

   pcie_axi_mem_slave_if axi();

   pcie_axi_mem_slave #(.MEM_DEPTH_LG2(10), .BASE_ADDR(64'h0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s_axi (axi.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Lane k of pattern i is 32'hC0DE_0000 | i<<8 | k.
   function automatic logic [255:0] pat(input int i);
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[32*k +: 32] = 32'hC0DE_0000 | (32'(i) << 8) | 32'(k);
      return r;
   endfunction

   task automatic send_aw(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len);
      int n = 0;
      axi.s_axi_awid = id; axi.s_axi_awaddr = addr; axi.s_axi_awlen = len; axi.s_axi_awvalid = 1'b1;
      while (!axi.s_axi_awready && n < 50) begin @(posedge clk); #1; n++; end
      chk("aw_ready", axi.s_axi_awready, 1'b1);
      @(posedge clk); #1;
      axi.s_axi_awvalid = 1'b0;
      chk("wready_next_cycle", axi.s_axi_wready, 1'b1);
      chk("awready_busy", axi.s_axi_awready, 1'b0);
   endtask

   task automatic send_w(input int nbeats, input int last_idx, input logic [31:0] strb);
      for (int i = 0; i < nbeats; i++) begin
         int n = 0;
         axi.s_axi_wvalid = 1'b1; axi.s_axi_wdata = wd[i]; axi.s_axi_wstrb = strb;
         axi.s_axi_wlast = (i == last_idx);
         while (!axi.s_axi_wready && n < 50) begin @(posedge clk); #1; n++; end
         chk("w_ready", axi.s_axi_wready, 1'b1);
         @(posedge clk); #1;
      end
      axi.s_axi_wvalid = 1'b0; axi.s_axi_wlast = 1'b0;
   endtask

   task automatic get_b(input logic [5:0] id, input logic [1:0] resp);
      chk("bvalid_next_cycle", axi.s_axi_bvalid, 1'b1);
      chk("bid", axi.s_axi_bid, id);
      chk("bresp", axi.s_axi_bresp, resp);
      axi.s_axi_bready = 1'b1;
      @(posedge clk); #1;
      axi.s_axi_bready = 1'b0;
      chk("bvalid_drop", axi.s_axi_bvalid, 1'b0);
      chk("awready_return", axi.s_axi_awready, 1'b1);
   endtask

   task automatic send_ar(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len);
      int n = 0;
      axi.s_axi_arid = id; axi.s_axi_araddr = addr; axi.s_axi_arlen = len; axi.s_axi_arvalid = 1'b1;
      while (!axi.s_axi_arready && n < 50) begin @(posedge clk); #1; n++; end
      chk("ar_ready", axi.s_axi_arready, 1'b1);
      @(posedge clk); #1;
      axi.s_axi_arvalid = 1'b0;
      chk("rvalid_next_cycle", axi.s_axi_rvalid, 1'b1);
      chk("arready_busy", axi.s_axi_arready, 1'b0);
   endtask

   task automatic get_r(input int nbeats, input logic [5:0] id, input logic [1:0] resp, input bit toggle);
      int beat = 0;
      int cyc = 0;
      logic [255:0] held = '0;
      bit have_held = 1'b0;
      while (beat < nbeats && cyc < 200) begin
         axi.s_axi_rready = toggle ? (cyc % 2 == 0) : 1'b1;
         if (have_held) chk("rdata_hold", axi.s_axi_rdata, held);
         if (axi.s_axi_rvalid && axi.s_axi_rready) begin
            chk("rdata", axi.s_axi_rdata, rexp[beat]);
            chk("rlast", axi.s_axi_rlast, (beat == nbeats - 1));
            chk("rid", axi.s_axi_rid, id);
            chk("rresp", axi.s_axi_rresp, resp);
            beat++;
            have_held = 1'b0;
         end else if (axi.s_axi_rvalid) begin
            held = axi.s_axi_rdata;
            have_held = 1'b1;
         end
         @(posedge clk); #1;
         cyc++;
      end
      axi.s_axi_rready = 1'b0;
      chk("r_beat_count", beat, nbeats);
      chk("rvalid_drop", axi.s_axi_rvalid, 1'b0);
      chk("rdata_idle_zero", axi.s_axi_rdata, '0);
      chk("arready_return", axi.s_axi_arready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      axi.s_axi_awvalid = 0; axi.s_axi_awid = 0; axi.s_axi_awaddr = 0; axi.s_axi_awlen = 0;
      axi.s_axi_wvalid = 0; axi.s_axi_wdata = 0; axi.s_axi_wstrb = 0; axi.s_axi_wlast = 0;
      axi.s_axi_bready = 0;
      axi.s_axi_arvalid = 0; axi.s_axi_arid = 0; axi.s_axi_araddr = 0; axi.s_axi_arlen = 0;
      axi.s_axi_rready = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_awready", axi.s_axi_awready, 1'b1);
      chk("rst_arready", axi.s_axi_arready, 1'b1);
      chk("rst_wready", axi.s_axi_wready, 1'b0);
      chk("rst_bvalid", axi.s_axi_bvalid, 1'b0);
      chk("rst_rvalid", axi.s_axi_rvalid, 1'b0);
      chk("rst_rlast", axi.s_axi_rlast, 1'b0);
      chk("rst_bid", axi.s_axi_bid, 6'd0);
      chk("rst_rid", axi.s_axi_rid, 6'd0);
      chk("rst_bresp", axi.s_axi_bresp, 2'd0);
      chk("rst_rresp", axi.s_axi_rresp, 2'd0);
      chk("rst_rdata", axi.s_axi_rdata, '0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 4-beat write at 0x40 (words 2..5), then read back
      for (int i = 0; i < 4; i++) begin wd[i] = pat(i); rexp[i] = pat(i); end
      send_aw(6'd5, 64'h40, 8'd3);
      send_w(4, 3, 32'hFFFF_FFFF);
      get_b(6'd5, 2'b00);
      send_ar(6'd9, 64'h40, 8'd3);
      get_r(4, 6'd9, 2'b00, 1'b0);

      // Partial strobe over all-ones word 2
      wd[0] = '1;
      send_aw(6'd3, 64'h40, 8'd0);
      send_w(1, 0, 32'hFFFF_FFFF);
      get_b(6'd3, 2'b00);
      wd[0] = {8{32'h1122_3344}};
      send_aw(6'd3, 64'h40, 8'd0);
      send_w(1, 0, 32'h0000_000F);
      get_b(6'd3, 2'b00);
      rexp[0] = {{224{1'b1}}, 32'h1122_3344};
      send_ar(6'd1, 64'h40, 8'd0);
      get_r(1, 6'd1, 2'b00, 1'b0);

      // 8-beat burst at 0x200 read back with rready toggling
      for (int i = 0; i < 8; i++) begin wd[i] = pat(10 + i); rexp[i] = pat(10 + i); end
      send_aw(6'd7, 64'h200, 8'd7);
      send_w(8, 7, 32'hFFFF_FFFF);
      get_b(6'd7, 2'b00);
      send_ar(6'd12, 64'h200, 8'd7);
      get_r(8, 6'd12, 2'b00, 1'b1);

      // Same-cycle write and read of word 30: read sees old data
      wd[0] = pat(20);
      send_aw(6'd1, 64'h3C0, 8'd0);
      send_w(1, 0, 32'hFFFF_FFFF);
      get_b(6'd1, 2'b00);
      axi.s_axi_awid = 6'd2; axi.s_axi_awaddr = 64'h3C0; axi.s_axi_awlen = 8'd0; axi.s_axi_awvalid = 1'b1;
      axi.s_axi_arid = 6'd3; axi.s_axi_araddr = 64'h3C0; axi.s_axi_arlen = 8'd0; axi.s_axi_arvalid = 1'b1;
      @(posedge clk); #1;
      axi.s_axi_awvalid = 1'b0; axi.s_axi_arvalid = 1'b0;
      chk("conc_wready", axi.s_axi_wready, 1'b1);
      chk("conc_rvalid", axi.s_axi_rvalid, 1'b1);
      chk("conc_arready_busy", axi.s_axi_arready, 1'b0);
      axi.s_axi_wvalid = 1'b1; axi.s_axi_wdata = pat(21); axi.s_axi_wstrb = 32'hFFFF_FFFF;
      axi.s_axi_wlast = 1'b1; axi.s_axi_rready = 1'b1;
      chk("conc_rdata_old", axi.s_axi_rdata, pat(20));
      chk("conc_rlast", axi.s_axi_rlast, 1'b1);
      chk("conc_rid", axi.s_axi_rid, 6'd3);
      @(posedge clk); #1;
      axi.s_axi_wvalid = 1'b0; axi.s_axi_wlast = 1'b0; axi.s_axi_rready = 1'b0;
      chk("conc_rvalid_drop", axi.s_axi_rvalid, 1'b0);
      get_b(6'd2, 2'b00);
      rexp[0] = pat(21);
      send_ar(6'd4, 64'h3C0, 8'd0);
      get_r(1, 6'd4, 2'b00, 1'b0);

`ifdef PCIE_AXI_MEM_ERR_CHECK_EN
      // Out-of-range write is DECERR and leaves word 0 alone
      wd[0] = pat(50);
      send_aw(6'd6, 64'h0, 8'd0);
      send_w(1, 0, 32'hFFFF_FFFF);
      get_b(6'd6, 2'b00);
      wd[0] = pat(51);
      send_aw(6'd7, 64'h8000, 8'd0);
      send_w(1, 0, 32'hFFFF_FFFF);
      get_b(6'd7, 2'b11);
      rexp[0] = pat(50);
      send_ar(6'd8, 64'h0, 8'd0);
      get_r(1, 6'd8, 2'b00, 1'b0);
      // Out-of-range read returns zero data with DECERR
      rexp[0] = '0;
      send_ar(6'd9, 64'h8000, 8'd0);
      get_r(1, 6'd9, 2'b11, 1'b0);
      // Burst straddling the top of memory
      wd[0] = pat(52); wd[1] = pat(53);
      send_aw(6'd10, 64'h7FE0, 8'd1);
      send_w(2, 1, 32'hFFFF_FFFF);
      get_b(6'd10, 2'b11);
      // awlen=3 but wlast on the third beat
      for (int i = 0; i < 3; i++) wd[i] = pat(60 + i);
      send_aw(6'd11, 64'h400, 8'd3);
      send_w(3, 2, 32'hFFFF_FFFF);
      get_b(6'd11, 2'b10);
`else
      // Burst from the last word wraps to word 0
      wd[0] = pat(40); wd[1] = pat(41);
      rexp[0] = pat(40); rexp[1] = pat(41);
      send_aw(6'd10, 64'h7FE0, 8'd1);
      send_w(2, 1, 32'hFFFF_FFFF);
      get_b(6'd10, 2'b00);
      send_ar(6'd11, 64'h7FE0, 8'd1);
      get_r(2, 6'd11, 2'b00, 1'b0);
      rexp[0] = pat(41);
      send_ar(6'd12, 64'h0, 8'd0);
      get_r(1, 6'd12, 2'b00, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
